// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: op encodings,
// FSM state encoding and small op-decoding helpers.
package divider_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/divider_param_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           q_bit;

    // rem_i < dvsr_i always holds, so trial[WIDTH] is exactly the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_i};
        q_bit   = ~trial[WIDTH];
        rem_o   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/divider_param.sv
// Multi-cycle signed/unsigned divider retiring BITS_PER_CYCLE quotient bits
// per cycle; divide-by-zero and signed overflow skip the iteration phase.
module divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]   rem_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0]   quo_chain [BITS_PER_CYCLE+1];

    logic               a_neg, b_neg, overflow;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            div_step #(.WIDTH(WIDTH)) u_step (
                .rem_i  (rem_chain[gi]),
                .quo_i  (quo_chain[gi]),
                .dvsr_i (dvsr_q),
                .rem_o  (rem_chain[gi+1]),
                .quo_o  (quo_chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        a_neg    = op_is_signed(op) & dividend[WIDTH-1];
        b_neg    = op_is_signed(op) & divisor[WIDTH-1];
        abs_a    = a_neg ? -dividend : dividend;
        abs_b    = b_neg ? -divisor : divisor;
        overflow = op_is_signed(op)
                   && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                   && (divisor == {WIDTH{1'b1}});

        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    busy_d = 1'b1;
                    dvsr_d = abs_b;
                    // Special cases preload final values; FIX then passes them through unsigned.
                    if (divisor == '0) begin
                        quo_d     = '1;
                        rem_d     = dividend;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = ST_FIX;
                    end else if (overflow) begin
                        quo_d     = dividend;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = ST_FIX;
                    end else begin
                        quo_d     = abs_a;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(N - 1);
                        state_d   = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                quo_d = quo_chain[BITS_PER_CYCLE];
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                case (op_q)
                    OP_DIV, OP_DIVU: result_d = neg_quo_q ? -quo_q : quo_q;
                    default:         result_d = neg_rem_q ? -rem_q : rem_q;
                endcase
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
